// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response buffer, redirect flush/drain.
// Latency: instr_valid the cycle after a response; requests stall when in-flight + buffered reach IBUF_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);
    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
    localparam logic [31:0]   PC0     = RESET_PC & ~32'h3;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] count;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_instr [IBUF_DEPTH];
    logic [31:0]   buf_pc    [IBUF_DEPTH];

    logic          req_fire;
    logic          rsp_live;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [CW-1:0] redirect_inflight;
    logic [31:0]   target_aligned;

    // Credits cover both in-flight requests and buffered instructions, so the buffer never overflows.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = ~reset & (state == FETCH) & (credit_used < {1'b0, DEPTH_C});
    assign imem_addr      = pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_live = imem_rsp_valid & (outstanding != '0);
    assign pop      = instr_valid & instr_ready;

    assign instr_valid = (count != '0);
    assign Instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    assign target_aligned    = redirect_target & ~32'h3;
    assign redirect_inflight = outstanding + CW'(req_fire) - CW'(rsp_live);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= PC0;
            rsp_pc      <= PC0;
            outstanding <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (redirect) begin
            // Everything still in flight, including a request accepted this cycle, must be drained.
            pc          <= target_aligned;
            rsp_pc      <= target_aligned;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= redirect_inflight;
            drop_cnt    <= redirect_inflight;
            state       <= (redirect_inflight != '0) ? DRAIN : FETCH;
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (state == FETCH) begin
                if (rsp_live) begin
                    buf_instr[wr_ptr] <= imem_rsp_data;
                    buf_pc[wr_ptr]    <= rsp_pc;
                    wr_ptr            <= wr_ptr + PW'(1);
                    rsp_pc            <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count       <= count + CW'(rsp_live) - CW'(pop);
                outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
            end else if (rsp_live) begin
                drop_cnt    <= drop_cnt - CW'(1);
                outstanding <= outstanding - CW'(1);
                if (drop_cnt == CW'(1)) begin
                    state <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table on a depth-4 instance with a queued memory, plus a wrap-around instance.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_instr_valid, a_instr_ready, a_redirect;
    logic [31:0] a_addr, a_rsp_data, a_instr, a_instr_pc, a_target;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_instr_valid, b_instr_ready, b_redirect;
    logic [31:0] b_addr, b_rsp_data, b_instr, b_instr_pc, b_target;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IBUF_DEPTH(4)) dut_a (
        .clk(clk), .reset(rst),
        .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_addr(a_addr),
        .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
        .instr_valid(a_instr_valid), .instr_ready(a_instr_ready), .Instr(a_instr),
        .instr_pc(a_instr_pc), .redirect(a_redirect), .redirect_target(a_target)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IBUF_DEPTH(4)) dut_b (
        .clk(clk), .reset(rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .Instr(b_instr),
        .instr_pc(b_instr_pc), .redirect(b_redirect), .redirect_target(b_target)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hE3A0_0001;
    endfunction

    // Instruction memory for dut_a: in-order, responds the cycle after accept unless held.
    logic [31:0] memq [$];
    logic [31:0] popped;
    logic        mem_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            memq.delete();
            a_rsp_valid <= 1'b0;
            a_rsp_data  <= '0;
        end else begin
            if (a_rsp_valid && memq.size() != 0) popped = memq.pop_front();
            if (a_req_valid && a_req_ready) memq.push_back(a_addr);
            if (!mem_hold && memq.size() != 0) begin
                a_rsp_valid <= 1'b1;
                a_rsp_data  <= mem_word(memq[0]);
            end else begin
                a_rsp_valid <= 1'b0;
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        irdy;
        logic        hold;
        logic        redir;
        logic [31:0] tgt;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic irdy, input logic hold, input logic redir,
                                input logic [31:0] tgt, input logic rv, input logic [31:0] addr,
                                input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.irdy = irdy; v.hold = hold; v.redir = redir; v.tgt = tgt;
        v.exp_rv = rv; v.exp_addr = addr; v.exp_iv = iv; v.exp_ipc = ipc;
        return v;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam int NV = 25;
    vec_t        vecs [NV];
    logic [31:0] b_exp_addr [5];
    logic        b_exp_rv [5];

    initial begin
        // Outputs shown are those seen before the row's inputs take effect at the next edge.
        //              rdy  irdy hold redir target        rv   addr          iv   instr_pc
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0000, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0004, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0008, 1'b1, 32'h0000);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h000C, 1'b1, 32'h0004);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0010, 1'b1, 32'h0004);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0014, 1'b1, 32'h0004);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0014, 1'b1, 32'h0004);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0014, 1'b1, 32'h0004);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0014, 1'b1, 32'h0008);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0018, 1'b1, 32'h000C);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h001C, 1'b1, 32'h0010);
        vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0020, 1'b1, 32'h0014);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0024, 1'b1, 32'h0018);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0103,   1'b1, 32'h0028, 1'b1, 32'h001C);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0100, 1'b0, 32'h0);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0100, 1'b0, 32'h0);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0100, 1'b0, 32'h0);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0100, 1'b0, 32'h0);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0104, 1'b0, 32'h0);
        vecs[19] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0200,   1'b1, 32'h0108, 1'b1, 32'h0100);
        vecs[20] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0200, 1'b0, 32'h0);
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0200, 1'b0, 32'h0);
        vecs[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0204, 1'b0, 32'h0);
        vecs[23] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h0300,   1'b1, 32'h0208, 1'b1, 32'h0200);
        vecs[24] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0300, 1'b0, 32'h0);

        b_exp_addr[0] = 32'hFFFF_FFF8; b_exp_rv[0] = 1'b1;
        b_exp_addr[1] = 32'hFFFF_FFFC; b_exp_rv[1] = 1'b1;
        b_exp_addr[2] = 32'h0000_0000; b_exp_rv[2] = 1'b1;
        b_exp_addr[3] = 32'h0000_0004; b_exp_rv[3] = 1'b1;
        b_exp_addr[4] = 32'h0000_0008; b_exp_rv[4] = 1'b0;

        rst = 1'b1;
        a_req_ready = 1'b0; a_instr_ready = 1'b0; a_redirect = 1'b0; a_target = '0; mem_hold = 1'b0;
        b_req_ready = 1'b1; b_rsp_valid = 1'b0; b_rsp_data = '0;
        b_instr_ready = 1'b1; b_redirect = 1'b0; b_target = '0;

        repeat (2) @(negedge clk);
        #1;
        check("reset req_valid", {31'b0, a_req_valid}, 32'h0);
        check("reset instr_valid", {31'b0, a_instr_valid}, 32'h0);
        check("reset Instr", a_instr, 32'h0);
        check("reset instr_pc", a_instr_pc, 32'h0);
        check("reset addr", a_addr, 32'h0);
        check("reset b req_valid", {31'b0, b_req_valid}, 32'h0);
        check("reset b addr", b_addr, 32'hFFFF_FFF8);

        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NV; k++) begin
            #1;
            check($sformatf("row%0d req_valid", k), {31'b0, a_req_valid}, {31'b0, vecs[k].exp_rv});
            check($sformatf("row%0d addr", k), a_addr, vecs[k].exp_addr);
            check($sformatf("row%0d instr_valid", k), {31'b0, a_instr_valid}, {31'b0, vecs[k].exp_iv});
            if (vecs[k].exp_iv) begin
                check($sformatf("row%0d instr_pc", k), a_instr_pc, vecs[k].exp_ipc);
                check($sformatf("row%0d Instr", k), a_instr, mem_word(vecs[k].exp_ipc));
            end
            if (k < 5) begin
                check($sformatf("wrap%0d req_valid", k), {31'b0, b_req_valid}, {31'b0, b_exp_rv[k]});
                check($sformatf("wrap%0d addr", k), b_addr, b_exp_addr[k]);
            end
            if (k == 2) check("first Instr", a_instr, 32'hE3A0_0001);
            a_req_ready   = vecs[k].rdy;
            a_instr_ready = vecs[k].irdy;
            mem_hold      = vecs[k].hold;
            a_redirect    = vecs[k].redir;
            a_target      = vecs[k].tgt;
            @(negedge clk);
        end

        // dut_a is now draining one stale response; hit reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        check("async req_valid", {31'b0, a_req_valid}, 32'h0);
        check("async instr_valid", {31'b0, a_instr_valid}, 32'h0);
        check("async Instr", a_instr, 32'h0);
        check("async instr_pc", a_instr_pc, 32'h0);
        check("async addr", a_addr, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        a_req_ready = 1'b1; a_instr_ready = 1'b1; mem_hold = 1'b0; a_redirect = 1'b0; a_target = '0;
        #1;
        check("restart req_valid", {31'b0, a_req_valid}, 32'h1);
        check("restart addr0", a_addr, 32'h0);
        @(negedge clk);
        #1;
        check("restart addr1", a_addr, 32'h4);
        check("restart instr_valid early", {31'b0, a_instr_valid}, 32'h0);
        @(negedge clk);
        #1;
        check("restart instr_valid", {31'b0, a_instr_valid}, 32'h1);
        check("restart instr_pc", a_instr_pc, 32'h0);
        check("restart Instr", a_instr, 32'hE3A0_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
